// File: rtl/mem_pkg.sv
// Shared encodings for the byte-serial memory arbiter: FSM states, access
// sizes, the UART address prefix and the size-to-byte-count helper.
package mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam logic [1:0] SZ_WORD   = 2'd2;
    localparam logic [1:0] IO_PREFIX = 2'b11;

    // Size 3 is not a legal encoding; it is treated as a word.
    function automatic logic [2:0] byte_cnt(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: grants the first requester strictly after the
// previously granted channel, wrapping back to channel 0.
module rr_arbiter #(
    parameter int NUM_CH = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [NUM_CH-1:0] last_grant_i,
    output logic [NUM_CH-1:0] grant_o
);

    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] hi_req;
    logic [NUM_CH-1:0] pick;
    logic              seen;

    // mask marks channels above the last grant; those win before wrap-around
    always_comb begin
        mask = '0;
        seen = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask[i] = seen;
            seen    = seen | last_grant_i[i];
        end
    end

    assign hi_req = req_i & mask;
    assign pick   = (|hi_req) ? hi_req : req_i;

    always_comb begin
        grant_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pick[i]) begin
                grant_o    = '0;
                grant_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Multi-channel arbiter onto a byte-wide synchronous memory: one request at a
// time, split into little-endian byte beats, with UART back-pressure and flush.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     flush_in,
    input  logic [NUM_CH-1:0]        req_valid,
    input  logic [NUM_CH*ADDR_W-1:0] req_addr,
    input  logic [NUM_CH*32-1:0]     req_wdata,
    input  logic [NUM_CH-1:0]        req_wr,
    input  logic [NUM_CH*2-1:0]      req_size,
    input  logic [NUM_CH-1:0]        req_signed,
    output logic [NUM_CH-1:0]        req_grant,
    output logic [NUM_CH-1:0]        resp_valid,
    output logic [31:0]              resp_data,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] gnt_q, rr_gnt;
    logic [ADDR_W-1:0] addr_q, beat_addr, sel_addr;
    logic [3:0][7:0]   wdata_q, data_q;
    logic [31:0]       sel_wdata;
    logic [1:0]        size_q, sel_size, cap_idx_q;
    logic              sgn_q, wr_q, sel_sgn, sel_wr, iss_q;
    logic [2:0]        cnt_q, nbytes;
    logic              gnt_fire, rd_issue, wr_issue, io_hold, beat_act;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
        .req_i        (req_valid),
        .last_grant_i (gnt_q),
        .grant_o      (rr_gnt)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_size  = '0;
        sel_wr    = 1'b0;
        sel_sgn   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rr_gnt[c]) begin
                sel_addr  = req_addr[c*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[c*32 +: 32];
                sel_size  = req_size[c*2 +: 2];
                sel_wr    = req_wr[c];
                sel_sgn   = req_signed[c];
            end
        end
    end

    assign nbytes    = byte_cnt(size_q);
    assign beat_addr = addr_q + ADDR_W'(cnt_q);
    assign io_hold   = (state_q == S_WR) && (beat_addr[17:16] == IO_PREFIX) && io_buffer_full;
    assign gnt_fire  = rst_in && rdy_in && !flush_in && (state_q == S_IDLE) && (|req_valid);
    assign rd_issue  = (state_q == S_RD) && rdy_in && !flush_in && (cnt_q < nbytes);
    assign wr_issue  = (state_q == S_WR) && rdy_in && !io_hold;
    assign beat_act  = ((state_q == S_RD) && (cnt_q < nbytes)) || (state_q == S_WR);

    assign req_grant  = gnt_fire ? rr_gnt : '0;
    assign mem_wr     = wr_issue;
    assign mem_a      = beat_act ? beat_addr : '0;
    assign mem_dout   = (state_q == S_WR) ? wdata_q[cnt_q[1:0]] : 8'h00;
    assign resp_valid = ((state_q == S_FIN) && rdy_in) ? gnt_q : '0;

    always_comb begin
        resp_data = '0;
        if ((state_q == S_FIN) && !wr_q) begin
            case (size_q)
                SZ_BYTE: resp_data = {{24{sgn_q & data_q[0][7]}}, data_q[0]};
                SZ_HALF: resp_data = {{16{sgn_q & data_q[1][7]}}, data_q[1], data_q[0]};
                default: resp_data = data_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (gnt_fire) state_d = sel_wr ? S_WR : S_RD;
            S_RD: begin
                if (rdy_in) begin
                    if (flush_in)              state_d = S_IDLE;
                    else if (cnt_q == nbytes)  state_d = S_FIN;
                end
            end
            // a flush never interrupts a store once it is accepted
            S_WR:   if (wr_issue && (cnt_q == nbytes - 3'd1)) state_d = S_FIN;
            S_FIN:  if (rdy_in) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= S_IDLE;
            gnt_q     <= {1'b1, {(NUM_CH-1){1'b0}}};
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            size_q    <= '0;
            sgn_q     <= 1'b0;
            wr_q      <= 1'b0;
            cnt_q     <= '0;
            iss_q     <= 1'b0;
            cap_idx_q <= '0;
        end else begin
            state_q <= state_d;
            // Read returns arrive one cycle after their beat and are taken even
            // during a stall, so a frozen mem_a cannot overwrite them.
            iss_q     <= rd_issue;
            cap_idx_q <= cnt_q[1:0];
            if (iss_q) data_q[cap_idx_q] <= mem_din;
            if (gnt_fire) begin
                gnt_q   <= rr_gnt;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                size_q  <= sel_size;
                sgn_q   <= sel_sgn;
                wr_q    <= sel_wr;
                cnt_q   <= '0;
            end else if (rd_issue || wr_issue) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

endmodule
